// File: rtl/fadc_sample_acc.sv
// Flash-ADC sample accumulator: thermometer capture, binary decode, power-of-two sum, valid/ready output.
// Optional bubble correction ahead of the encoder is enabled by defining FADC_BUBBLE_CORR_EN.
module fadc_sample_acc #(
    parameter int unsigned N_COMP   = 15,
    parameter int unsigned ACC_LOG2 = 4,
    localparam int unsigned BIN_W   = $clog2(N_COMP + 1),
    localparam int unsigned SUM_W   = BIN_W + ACC_LOG2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_COMP-1:0] thermo_in,
    input  logic              thermo_vld,
    output logic [SUM_W-1:0]  sum_out,
    output logic              sum_vld,
    input  logic              sum_rdy,
    output logic              busy,
    output logic              drop
);

    localparam int unsigned CNT_W       = ACC_LOG2 + 1;
    localparam int unsigned NUM_SAMPLES = 1 << ACC_LOG2;

    typedef enum logic [1:0] {IDLE, ACC, FLUSH, HOLD} state_t;

    state_t            state;
    logic [N_COMP-1:0] s1_word;
    logic              s1_vld;
    logic [N_COMP-1:0] enc_word;
    logic [BIN_W-1:0]  bin;
    logic [CNT_W-1:0]  cnt;
    logic [SUM_W-1:0]  acc;

`ifdef FADC_BUBBLE_CORR_EN
    // Three-tap majority vote, padded with 1 below bit 0 and 0 above the top bit.
    logic [N_COMP+1:0] ext;
    assign ext = {1'b0, s1_word, 1'b1};

    always_comb begin
        enc_word = '0;
        for (int i = 0; i < int'(N_COMP); i++) begin
            enc_word[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
        end
    end
`else
    assign enc_word = s1_word;
`endif

    // Priority encode: highest set bit index plus one.
    always_comb begin
        bin = '0;
        for (int i = 0; i < int'(N_COMP); i++) begin
            if (enc_word[i]) bin = BIN_W'(i + 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            s1_word <= '0;
            s1_vld  <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            sum_out <= '0;
            sum_vld <= 1'b0;
            busy    <= 1'b0;
            drop    <= 1'b0;
        end else begin
            drop   <= thermo_vld && (state != ACC);
            s1_vld <= 1'b0;
            if (s1_vld) acc <= acc + SUM_W'(bin);

            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        acc   <= '0;
                        cnt   <= '0;
                        state <= ACC;
                    end
                end
                ACC: begin
                    busy <= 1'b1;
                    if (thermo_vld) begin
                        s1_word <= thermo_in;
                        s1_vld  <= 1'b1;
                        cnt     <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(NUM_SAMPLES - 1)) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    busy  <= 1'b1;
                    state <= HOLD;
                end
                HOLD: begin
                    // First HOLD cycle latches the completed sum; it stays frozen until accepted.
                    if (!sum_vld) begin
                        sum_vld <= 1'b1;
                        sum_out <= acc;
                    end else if (sum_rdy) begin
                        sum_vld <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fadc_sample_acc.sv
// Directed self-checking bench for fadc_sample_acc (default build plus an ACC_LOG2=0 instance).
module tb_fadc_sample_acc;

    logic        clk;
    logic        rst;
    logic        start;
    logic [14:0] thermo_in;
    logic        thermo_vld;
    logic [7:0]  sum_out;
    logic        sum_vld;
    logic        sum_rdy;
    logic        busy;
    logic        drop;

    logic        start1;
    logic [14:0] thermo_in1;
    logic        thermo_vld1;
    logic [3:0]  sum_out1;
    logic        sum_vld1;
    logic        sum_rdy1;
    logic        busy1;
    logic        drop1;

    int checks = 0;
    int errors = 0;

    fadc_sample_acc dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .thermo_in  (thermo_in),
        .thermo_vld (thermo_vld),
        .sum_out    (sum_out),
        .sum_vld    (sum_vld),
        .sum_rdy    (sum_rdy),
        .busy       (busy),
        .drop       (drop)
    );

    fadc_sample_acc #(.N_COMP(15), .ACC_LOG2(0)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start1),
        .thermo_in  (thermo_in1),
        .thermo_vld (thermo_vld1),
        .sum_out    (sum_out1),
        .sum_vld    (sum_vld1),
        .sum_rdy    (sum_rdy1),
        .busy       (busy1),
        .drop       (drop1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Start, 16 back-to-back samples, then exact latency and one-cycle handshake with sum_rdy=1.
    task automatic conv_fixed(input logic [14:0] word, input int exp_v, input string tag,
                              input bit with_drop);
        sum_rdy    = 1'b1;
        start      = 1'b1;
        thermo_vld = with_drop;
        thermo_in  = 15'h7FFF;
        step;
        start      = 1'b0;
        thermo_vld = 1'b0;
        if (with_drop) chk({tag, "_start_drop"}, 32'(drop), 1);
        for (int i = 0; i < 16; i++) begin
            thermo_vld = 1'b1;
            thermo_in  = word;
            step;
            if (i == 0) chk({tag, "_busy_rise"}, 32'(busy), 1);
        end
        thermo_vld = 1'b0;
        step;
        chk({tag, "_vld_t1"}, 32'(sum_vld), 0);
        step;
        chk({tag, "_vld_t2"}, 32'(sum_vld), 1);
        chk({tag, "_sum"}, 32'(sum_out), 32'(exp_v));
        step;
        chk({tag, "_vld_fall"}, 32'(sum_vld), 0);
        chk({tag, "_busy_fall"}, 32'(busy), 0);
    endtask

    initial begin
        int exp_sum;
        int drops;
        int w;
        int k;

        rst = 1'b1; start = 1'b0; thermo_in = '0; thermo_vld = 1'b0; sum_rdy = 1'b0;
        start1 = 1'b0; thermo_in1 = '0; thermo_vld1 = 1'b0; sum_rdy1 = 1'b0;
        step;
        step;
        rst = 1'b0;
        chk("rst_sum_out", 32'(sum_out), 0);
        chk("rst_sum_vld", 32'(sum_vld), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_drop", 32'(drop), 0);

        conv_fixed(15'h00FF, 128, "ff", 1'b0);

        // Held output with back-pressure, drops and an ignored start in HOLD.
        sum_rdy = 1'b0;
        start   = 1'b1;
        step;
        start   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            thermo_vld = 1'b1;
            thermo_in  = 15'h7FFF;
            step;
        end
        thermo_vld = 1'b0;
        step;
        step;
        chk("hold_vld", 32'(sum_vld), 1);
        chk("hold_sum", 32'(sum_out), 240);
        drops = 0;
        for (int i = 0; i < 10; i++) begin
            thermo_vld = (i % 3 == 0) && (i < 9);
            start      = (i == 5);
            step;
            if (drop) drops++;
            chk("hold_vld_stable", 32'(sum_vld), 1);
            chk("hold_sum_stable", 32'(sum_out), 240);
            chk("hold_busy", 32'(busy), 1);
        end
        thermo_vld = 1'b0;
        start      = 1'b0;
        chk("hold_drops", 32'(drops), 3);
        sum_rdy = 1'b1;
        step;
        chk("hold_release_vld", 32'(sum_vld), 0);
        chk("hold_release_busy", 32'(busy), 0);

`ifdef FADC_BUBBLE_CORR_EN
        conv_fixed(15'h0107, 48, "bubble", 1'b1);
`else
        conv_fixed(15'h0107, 144, "bubble", 1'b1);
`endif

        // Random gaps, clean thermometer codes (value k), start pulse mid-accumulation.
        exp_sum = 0;
        drops   = 0;
        sum_rdy = 1'b1;
        start   = 1'b1;
        step;
        start   = 1'b0;
        for (int n = 0; n < 16; n++) begin
            repeat ($urandom_range(0, 3)) begin
                step;
                if (drop) drops++;
            end
            k          = int'($urandom_range(0, 15));
            thermo_in  = 15'((1 << k) - 1);
            thermo_vld = 1'b1;
            start      = (n == 5);
            exp_sum   += k;
            step;
            if (drop) drops++;
            thermo_vld = 1'b0;
            start      = 1'b0;
        end
        w = 0;
        while (!sum_vld && w < 10) begin
            step;
            if (drop) drops++;
            w++;
        end
        chk("rand_vld", 32'(sum_vld), 1);
        chk("rand_sum", 32'(sum_out), 32'(exp_sum));
        chk("rand_no_drop", 32'(drops), 0);
        step;
        chk("rand_vld_fall", 32'(sum_vld), 0);

        // Abort mid-conversion with reset.
        start = 1'b1;
        step;
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            thermo_vld = 1'b1;
            thermo_in  = 15'h7FFF;
            step;
        end
        thermo_vld = 1'b0;
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_vld", 32'(sum_vld), 0);
        thermo_vld = 1'b1;
        step;
        thermo_vld = 1'b0;
        chk("abort_idle_drop", 32'(drop), 1);
        conv_fixed(15'h0001, 16, "after_abort", 1'b0);

        // Single-sample instance.
        sum_rdy1 = 1'b1;
        for (int r = 0; r < 2; r++) begin
            start1 = 1'b1;
            step;
            start1      = 1'b0;
            thermo_in1  = (r == 0) ? 15'h0000 : 15'h001F;
            thermo_vld1 = 1'b1;
            step;
            thermo_vld1 = 1'b0;
            step;
            chk("one_vld_t1", 32'(sum_vld1), 0);
            step;
            chk("one_vld_t2", 32'(sum_vld1), 1);
            chk("one_sum", 32'(sum_out1), (r == 0) ? 0 : 5);
            step;
            chk("one_vld_fall", 32'(sum_vld1), 0);
            chk("one_busy_fall", 32'(busy1), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
